vr_vc_credit_arbiter: RTL

Round-robin scheduler that shares one valid/credit output link among NUM_REQ valid/ready requesters. It tracks the credits the downstream receiver has granted and issues a word only when a credit is held. A word is forwarded only when a credit is held, so the downstream buffer never overflows. It sits in front of a valid/credit-to-valid/ready receiver, which returns one credit pulse per freed buffer slot. That receiver also pulses CREDIT_NUM initial credits after reset.

---
 rtl/vr_vc_credit_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/vr_vc_credit_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready requesters onto one
// valid/credit link, forwarding a word only while a downstream credit is held.
module vr_vc_credit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_data_i,
  input  logic [NUM_REQ-1:0]               s_valid_i,
  output logic [NUM_REQ-1:0]               s_ready_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic                             m_valid_o,
  input  logic                             m_credit_i,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id_o,
  output logic [$clog2(CREDIT_NUM):0]      credit_cnt_o,
  output logic                             credit_ovf_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDIT_NUM) + 1;

  // Requester side: a word transfers on a cycle where s_valid_i[i] and
  // s_ready_o[i] are both high. Link side has no backpressure; each m_valid_o
  // cycle is one word and consumes one credit returned via m_credit_i.

  logic [CW-1:0]      cnt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      winner;
  logic [PW-1:0]      idx;
  logic               found;
  logic               send;
  logic [NUM_REQ-1:0] ready;

  // Search from ptr for the first valid requester; gated by held credits only.
  always_comb begin
    ready  = '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    if (cnt != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = PW'((int'(ptr) + k) % NUM_REQ);
        if (!found && s_valid_i[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
    if (found) ready[winner] = 1'b1;
  end

  assign s_ready_o    = ready;
  assign send         = |(s_valid_i & ready);
  assign credit_cnt_o = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      ptr          <= '0;
      credit_ovf_o <= 1'b0;
      m_valid_o    <= 1'b0;
      m_data_o     <= '0;
      grant_id_o   <= '0;
    end else begin
      m_valid_o <= send;
      if (send) begin
        m_data_o   <= s_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
        grant_id_o <= winner;
        ptr        <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
      end
      // A credit beyond CREDIT_NUM means the receiver lost track; flag it sticky.
      if (m_credit_i && !send) begin
        if (cnt == CW'(CREDIT_NUM)) credit_ovf_o <= 1'b1;
        else                        cnt <= cnt + CW'(1);
      end else if (send && !m_credit_i) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule
